ddu_step_ctrl: RTL and testbench

//   Debug-unit front end feeding the pipelined CPU top level.
//   - Conditions the board switches (cont, mem) and push buttons (step, inc, dec).
//   - Produces the CPU clock-enable that implements run/single-step.
//   - Produces the wrapping view address used by the register/memory display path.

---
 rtl/ddu_step_ctrl_if.sv | 31 +++
 rtl/ddu_step_ctrl.sv | 120 ++++++++++++
 tb/tb_ddu_step_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddu_step_ctrl_if.sv
// Debug-unit signal bundle between board I/O and ddu_step_ctrl.
// Latency: none (wires only).
// Backpressure: none; outputs are level signals sampled every clk_500 edge.
//
// Ports:
//   master: drives raw cont/step/mem/inc/dec and observes
//           cpu_en/view_addr/view_mem/step_cnt
//   slave : the step controller itself
interface ddu_step_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              cont;
  logic              step;
  logic              mem;
  logic              inc;
  logic              dec;
  logic              cpu_en;
  logic [ADDR_W-1:0] view_addr;
  logic              view_mem;
  logic [15:0]       step_cnt;

  modport master (
    output cont, step, mem, inc, dec,
    input  cpu_en, view_addr, view_mem, step_cnt
  );

  modport slave (
    input  cont, step, mem, inc, dec,
    output cpu_en, view_addr, view_mem, step_cnt
  );
endinterface

// File: rtl/ddu_step_ctrl.sv
// Debug front end: syncs switches, debounces buttons, makes CPU run/step enable and view address.
// Latency: switch -> output 2 edges; button press -> pulse in the cycle after edge 2+DB_CYCLES.
// Backpressure: none; cpu_en is a free-running enable sampled by the CPU every edge.
//
// Ports:
//   clk_500  system clock, rising edge
//   rst      synchronous reset, active low
//   dbg      ddu_step_ctrl_if.slave: raw cont/step/mem/inc/dec in;
//            cpu_en, view_addr, view_mem, step_cnt out
// Optional feature: define DDU_STEP_COUNT_EN to build the 16-bit cpu_en cycle
// counter; otherwise step_cnt reads as zero and no counter flops exist.
module ddu_step_ctrl #(
  parameter int DB_CYCLES = 4,
  parameter int ADDR_W    = 8
) (
  input  logic            clk_500,
  input  logic            rst,
  ddu_step_ctrl_if.slave  dbg
);

  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  // Button lane indices inside the packed button vectors.
  localparam int B_STEP = 0;
  localparam int B_INC  = 1;
  localparam int B_DEC  = 2;

  logic              cont_s1, cont_s2;
  logic              mem_s1, mem_s2, mem_s3;
  logic [2:0]        btn_s1, btn_s2;
  logic [2:0]        btn_db, btn_db_q;
  logic [2:0]        btn_pulse;
  logic [CW-1:0]     btn_cnt [3];
  logic [ADDR_W-1:0] view_addr;
  logic              cpu_en;

  always_ff @(posedge clk_500) begin
    if (!rst) begin
      cont_s1   <= 1'b0;
      cont_s2   <= 1'b0;
      mem_s1    <= 1'b0;
      mem_s2    <= 1'b0;
      mem_s3    <= 1'b0;
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_db    <= '0;
      btn_db_q  <= '0;
      btn_pulse <= '0;
      view_addr <= '0;
      for (int i = 0; i < 3; i++) begin
        btn_cnt[i] <= '0;
      end
    end else begin
      cont_s1 <= dbg.cont;
      cont_s2 <= cont_s1;
      mem_s1  <= dbg.mem;
      mem_s2  <= mem_s1;
      mem_s3  <= mem_s2;
      btn_s1  <= {dbg.dec, dbg.inc, dbg.step};
      btn_s2  <= btn_s1;

      // A level is accepted only after DB_CYCLES consecutive disagreeing
      // samples; any agreeing sample restarts the count.
      for (int i = 0; i < 3; i++) begin
        if (btn_s2[i] == btn_db[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == CNT_LAST) begin
          btn_db[i]  <= btn_s2[i];
          btn_cnt[i] <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + CNT_ONE;
        end
      end

      // Rising-edge detect on the registered debounced level: the pulse
      // register sets one edge after db settles and self-clears next edge.
      btn_db_q  <= btn_db;
      btn_pulse <= btn_db & ~btn_db_q;

      // Switching between register and memory view restarts at address 0
      // and swallows any inc/dec landing on the same edge.
      if (mem_s2 != mem_s3) begin
        view_addr <= '0;
      end else if (btn_pulse[B_INC] && btn_pulse[B_DEC]) begin
        view_addr <= view_addr;
      end else if (btn_pulse[B_INC]) begin
        view_addr <= view_addr + ADDR_ONE;
      end else if (btn_pulse[B_DEC]) begin
        view_addr <= view_addr - ADDR_ONE;
      end
    end
  end

  // Running continuously already enables every cycle, so a step pulse
  // under cont adds nothing.
  assign cpu_en        = cont_s2 | btn_pulse[B_STEP];
  assign dbg.cpu_en    = cpu_en;
  assign dbg.view_addr = view_addr;
  assign dbg.view_mem  = mem_s2;

`ifdef DDU_STEP_COUNT_EN
  logic [15:0] step_cnt_q;

  always_ff @(posedge clk_500) begin
    if (!rst) begin
      step_cnt_q <= '0;
    end else if (cpu_en) begin
      step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  assign dbg.step_cnt = step_cnt_q;
`else
  assign dbg.step_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ddu_step_ctrl.sv
// Bench for ddu_step_ctrl: directed scenarios plus random switch/button traffic,
// with every cycle compared against a history-based reference model.
module tb_ddu_step_ctrl;

  localparam int DB   = 4;
  localparam int AW   = 8;
  localparam int HMAX = 8192;

  // Raw input channel indices in the history words.
  localparam int C_CONT = 0;
  localparam int C_MEM  = 1;
  localparam int C_STEP = 2;
  localparam int C_INC  = 3;
  localparam int C_DEC  = 4;

  logic clk_500 = 1'b0;
  logic rst;

  always #5 clk_500 = ~clk_500;

  ddu_step_ctrl_if #(.ADDR_W(AW)) dif ();

  ddu_step_ctrl #(.DB_CYCLES(DB), .ADDR_W(AW)) dut (
    .clk_500 (clk_500),
    .rst     (rst),
    .dbg     (dif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per-edge history since the last reset. Index t is the
  // number of non-reset edges minus one; t = -1 means "just reset".
  bit [4:0] h_raw [HMAX];
  bit [2:0] h_db  [HMAX];
  int       h_va  [HMAX];
  int       h_sc  [HMAX];
  int       t = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
    end
  endtask

  function automatic bit raw(input int ch, input int k);
    return (k < 0) ? 1'b0 : h_raw[k][ch];
  endfunction

  function automatic bit dbv(input int b, input int k);
    return (k < 0) ? 1'b0 : h_db[k][b];
  endfunction

  // Pulse visible after edge k: accepted level rose between edges k-2 and k-1.
  function automatic bit pulse(input int b, input int k);
    return dbv(b, k - 1) & ~dbv(b, k - 2);
  endfunction

  function automatic bit en_after(input int k);
    if (k < 0) return 1'b0;
    return raw(C_CONT, k - 1) | pulse(0, k);
  endfunction

  task automatic model_edge();
    bit prev, all_flip, memchg, ip, dp;
    int pva, psc;
    if (rst !== 1'b1) begin
      t = -1;
      return;
    end
    t++;
    if (t >= HMAX) begin
      $display("FAIL model_history: index %0d exceeds %0d", t, HMAX);
      $fatal(1);
    end
    h_raw[t] = {dif.dec, dif.inc, dif.step, dif.mem, dif.cont};
    // Synchronised level used at edge k is the raw value sampled at edge k-2.
    // The accepted level flips once the last DB such samples all differ from it.
    for (int b = 0; b < 3; b++) begin
      prev     = dbv(b, t - 1);
      all_flip = 1'b1;
      for (int j = 0; j < DB; j++) begin
        if (raw(b + C_STEP, t - j - 2) == prev) all_flip = 1'b0;
      end
      h_db[t][b] = all_flip ? ~prev : prev;
    end
    memchg = raw(C_MEM, t - 2) != raw(C_MEM, t - 3);
    ip     = pulse(1, t - 1);
    dp     = pulse(2, t - 1);
    pva    = (t > 0) ? h_va[t - 1] : 0;
    if (memchg)        h_va[t] = 0;
    else if (ip && dp) h_va[t] = pva;
    else if (ip)       h_va[t] = (pva + 1) % (1 << AW);
    else if (dp)       h_va[t] = (pva + (1 << AW) - 1) % (1 << AW);
    else               h_va[t] = pva;
    psc = (t > 0) ? h_sc[t - 1] : 0;
`ifdef DDU_STEP_COUNT_EN
    h_sc[t] = (psc + int'(en_after(t - 1))) % 65536;
`else
    h_sc[t] = psc;
`endif
  endtask

  task automatic check_outputs();
    chk("cpu_en",    dif.cpu_en,    32'(en_after(t)));
    chk("view_mem",  dif.view_mem,  32'((t < 0) ? 1'b0 : raw(C_MEM, t - 1)));
    chk("view_addr", dif.view_addr, 32'((t < 0) ? 0 : h_va[t]));
    chk("step_cnt",  dif.step_cnt,  32'((t < 0) ? 0 : h_sc[t]));
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge,
  // caller then changes inputs while the clock is low.
  task automatic cycle();
    @(posedge clk_500);
    model_edge();
    @(negedge clk_500);
    check_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press(input bit do_inc, input bit do_dec);
    dif.inc = do_inc;
    dif.dec = do_dec;
    cycles(6);
    dif.inc = 1'b0;
    dif.dec = 1'b0;
    cycles(8);
  endtask

  task automatic count_en(input int n, output int ones, output int first);
    ones  = 0;
    first = -1;
    for (int k = 0; k < n; k++) begin
      cycle();
      if (dif.cpu_en === 1'b1) begin
        ones++;
        if (first < 0) first = k;
      end
    end
  endtask

  int ones, first, ones2, first2, sc0, all_on;

  initial begin
    // Reset with every input high.
    rst = 1'b0;
    dif.cont = 1'b1; dif.step = 1'b1; dif.mem = 1'b1; dif.inc = 1'b1; dif.dec = 1'b1;
    @(negedge clk_500);
    cycles(2);
    chk("rst_cpu_en",    dif.cpu_en,    32'd0);
    chk("rst_view_addr", dif.view_addr, 32'd0);
    chk("rst_view_mem",  dif.view_mem,  32'd0);
    chk("rst_step_cnt",  dif.step_cnt,  32'd0);
    rst = 1'b1;
    dif.cont = 1'b0; dif.step = 1'b0; dif.mem = 1'b0; dif.inc = 1'b0; dif.dec = 1'b0;
    cycles(10);

    // Held step press: single pulse in the cycle after edge 2+DB.
    sc0 = int'(dif.step_cnt);
    dif.step = 1'b1;
    count_en(20, ones, first);
    chk("step_pulses", 32'(ones), 32'd1);
    chk("step_edge",   32'(first), 32'(2 + DB));
`ifdef DDU_STEP_COUNT_EN
    chk("step_cnt_one", dif.step_cnt, 32'(sc0 + 1));
`else
    chk("step_cnt_tied", dif.step_cnt, 32'd0);
`endif
    dif.step = 1'b0;
    count_en(12, ones, first);
    chk("release_no_pulse", 32'(ones), 32'd0);

    // Glitch shorter than DB is ignored, DB-long press is accepted.
    dif.step = 1'b1;
    count_en(DB - 1, ones, first);
    dif.step = 1'b0;
    count_en(14, ones2, first2);
    chk("glitch_pulses", 32'(ones + ones2), 32'd0);
    dif.step = 1'b1;
    count_en(DB, ones, first);
    dif.step = 1'b0;
    count_en(14, ones2, first2);
    chk("min_press_pulses", 32'(ones + ones2), 32'd1);

    // View address wrap both ways and simultaneous inc/dec.
    press(1'b0, 1'b1);
    chk("dec_wrap", dif.view_addr, 32'hFF);
    press(1'b1, 1'b0);
    chk("inc_wrap", dif.view_addr, 32'h00);
    press(1'b1, 1'b1);
    chk("inc_dec_hold", dif.view_addr, 32'h00);

    // mem toggle landing on the same edge as an inc pulse.
    for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
    chk("addr_five", dif.view_addr, 32'h05);
    dif.inc = 1'b1;
    cycles(5);
    dif.mem = 1'b1;
    cycle();
    chk("mem_lag1", dif.view_mem, 32'd0);
    cycle();
    chk("mem_lag2", dif.view_mem, 32'd1);
    chk("addr_before_clr", dif.view_addr, 32'h05);
    cycle();
    chk("mem_clears_addr", dif.view_addr, 32'h00);
    dif.inc = 1'b0;
    cycles(10);
    chk("addr_after_clr", dif.view_addr, 32'h00);

    // Continuous run.
    dif.cont = 1'b1;
    cycles(2);
    sc0    = int'(dif.step_cnt);
    all_on = 1;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (dif.cpu_en !== 1'b1) all_on = 0;
    end
    chk("cont_all_on", 32'(all_on), 32'd1);
`ifdef DDU_STEP_COUNT_EN
    chk("cont_step_cnt", dif.step_cnt, 32'((sc0 + 100) % 65536));
`else
    chk("cont_step_cnt", dif.step_cnt, 32'd0);
`endif
    rst = 1'b0;
    cycle();
    chk("midrun_cpu_en",    dif.cpu_en,    32'd0);
    chk("midrun_view_addr", dif.view_addr, 32'd0);
    chk("midrun_view_mem",  dif.view_mem,  32'd0);
    chk("midrun_step_cnt",  dif.step_cnt,  32'd0);
    rst = 1'b1;
    dif.cont = 1'b0; dif.mem = 1'b0;
    cycles(4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0)   dif.step = ~dif.step;
      if ($urandom_range(0, 7) == 0)   dif.inc  = ~dif.inc;
      if ($urandom_range(0, 7) == 0)   dif.dec  = ~dif.dec;
      if ($urandom_range(0, 39) == 0)  dif.cont = ~dif.cont;
      if ($urandom_range(0, 59) == 0)  dif.mem  = ~dif.mem;
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
